register_file_plus_alu: RTL and testbench
=========================================

# register_file_plus_alu

Datapath core of the 16-bit CPU: an 8-entry × 16-bit register file with one synchronous write port and two combinational read ports, feeding a combinational add/subtract ALU. The ALU also performs load-high/load-low immediate merges. A registered output latch (OutR) captures the ALU result under control-unit command. The block sits between instruction decode (addresses, immediates, control strobes) and writeback, which drives RF_data.

## Interface
Parameters: none (width 16 and depth 8 are fixed).

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-high despite the name
- RF_en  in  1  register-file write enable
- RF_addr  in  3  write address
- RF_data  in  16  write data
- read_A  in  3  read address, port A
- read_B  in  3  read address, port B
- rA  out  16  register[read_A], combinational
- rB  out  16  register[read_B], combinational
- add_or_sub  in  1  0 = add, 1 = subtract
- out_imm  in  1  1 = ALU operand B is ext_B_data; 0 = operand B is rB
- ext_B_data  in  16  extended immediate operand
- LHI  in  1  load-high-immediate select
- LLI  in  1  load-low-immediate select
- S_out  out  16  ALU result, combinational
- N, Z, V, C  out  1 each  negative, zero, signed overflow, carry flags; combinational
- ctro_outR  in  1  OutR load enable
- OutR  out  16  registered result

## Operation
- Register file: 8 × 16-bit entries R0–R7, all writable (R0 is not hardwired). Write R[RF_addr] <= RF_data on the clock edge when RF_en=1 and rst_n=0.
- Reads are asynchronous. Without the bypass option, a read of the address being written returns the old value until the edge.
- Operand A = rA. Operand B = out_imm ? ext_B_data : rB.
- Arithmetic, 17-bit internal:
  - add: {C, sum} = A + B.
  - sub: {C, sum} = A + ~B + 1, so C=1 means no borrow.
  - V = signed overflow of the 16-bit operation.
- Result select, priority LHI > LLI > arithmetic:
  - LHI: S_out = {B[7:0], A[7:0]}.
  - LLI: S_out = {A[15:8], B[7:0]}.
  - Otherwise: S_out = sum.
- Flags:
  - N = S_out[15].
  - Z = (S_out == 0).
  - V and C come from the adder in arithmetic mode and are forced to 0 when LHI or LLI is active.
- OutR <= S_out on the clock edge when ctro_outR=1; otherwise it holds its value.

## Timing
- Reset (rst_n=1 at an edge): R0–R7 <= 0 and OutR <= 0. Reset has priority over RF_en and ctro_outR. rA, rB, S_out and the flags then follow combinationally from the zeroed registers.
- Write latency: one edge. The new value is visible on rA/rB immediately after the edge.
- Same-cycle RF write and ctro_outR: OutR captures S_out computed from pre-edge register values.
- Combinational path: read address → rA/rB → S_out/flags. No pipeline stages.
- Adder wrap-around is modulo 2^16. Overflow is reported only via C and V.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding. When RF_en=1 and RF_addr equals read_A (or read_B), rA (or rB) returns RF_data in the same cycle. Bypass is suppressed while rst_n=1.
- RF_BYPASS_EN undefined: reads return stored contents only.

## Test plan
- Reset: write assorted values, assert rst_n=1 for one edge, then read all 8 addresses -> every rA/rB = 0x0000 and OutR = 0x0000.
- Write/read: RF_en=1, RF_addr=1, RF_data=0x1111; after the edge set read_B=1 -> rB=0x1111. Reading an unwritten R5 via read_A -> 0x0000.
- Add with immediate:
  - Setup: R1=0x1111, read_A=1, out_imm=1, ext_B_data=0x00FF, add.
  - Expect: S_out=0x1210, N=Z=V=C=0.
  - Overflow case: 0x7FFF+0x0001 -> 0x8000 with N=1, V=1, C=0.
- Subtract:
  - R7=0xAAAA, R3=0, read_A=7, read_B=3, out_imm=0, sub -> S_out=0xAAAA, N=1, C=1, V=0.
  - Equal operands -> S_out=0, Z=1, C=1.
  - 0x0000−0x0001 -> 0xFFFF, C=0.
- LHI/LLI:
  - rA=0x1111, ext_B_data=0x9999, LHI=1 -> S_out=0x9911, V=C=0.
  - Same inputs with LHI=0, LLI=1 -> 0x1199.
  - LHI=LLI=1 -> 0x9911 (LHI wins).
- OutR latch:
  - ctro_outR=1 at the edge with S_out=0x1210 -> OutR=0x1210.
  - ctro_outR=0 while S_out changes -> OutR holds.
  - With RF_BYPASS_EN: same-cycle write R2=0x5555 with read_A=2 -> rA=0x5555 before the edge.

Source files
------------

// File: rtl/register_file_plus_alu.sv
// 8x16 register file with two async read ports feeding an add/sub/LHI/LLI ALU and OutR latch.
// Optional RF_BYPASS_EN macro enables same-cycle write-through forwarding on rA/rB.
module register_file_plus_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RF_en,
  input  logic [2:0]  RF_addr,
  input  logic [15:0] RF_data,
  input  logic [2:0]  read_A,
  input  logic [2:0]  read_B,
  output logic [15:0] rA,
  output logic [15:0] rB,
  input  logic        add_or_sub,
  input  logic        out_imm,
  input  logic [15:0] ext_B_data,
  input  logic        LHI,
  input  logic        LLI,
  output logic [15:0] S_out,
  output logic        N,
  output logic        Z,
  output logic        V,
  output logic        C,
  input  logic        ctro_outR,
  output logic [15:0] OutR
);

  logic [15:0] regs [8];

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] b_inv;
  logic [16:0] sum17;
  logic        v_arith;
  logic        arith;

  // rst_n is an active-high synchronous reset despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      OutR <= '0;
    end else begin
      if (RF_en) begin
        regs[RF_addr] <= RF_data;
      end
      if (ctro_outR) begin
        OutR <= S_out;
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = RF_en && !rst_n
              && (RF_addr == read_A);
  assign fwd_b = RF_en && !rst_n
              && (RF_addr == read_B);
  assign rA = fwd_a ? RF_data : regs[read_A];
  assign rB = fwd_b ? RF_data : regs[read_B];
`else
  assign rA = regs[read_A];
  assign rB = regs[read_B];
`endif

  assign op_a = rA;
  assign op_b = out_imm ? ext_B_data : rB;

  // subtract as A + ~B + 1 so the carry-out means "no borrow"
  assign b_inv = add_or_sub ? ~op_b : op_b;
  assign sum17 = {1'b0, op_a}
               + {1'b0, b_inv}
               + {16'd0, add_or_sub};

  assign v_arith = (op_a[15] == b_inv[15])
                && (sum17[15] != op_a[15]);

  assign arith = !LHI && !LLI;

  always_comb begin
    S_out = sum17[15:0];
    if (LHI) begin
      S_out = {op_b[7:0], op_a[7:0]};
    end else if (LLI) begin
      S_out = {op_a[15:8], op_b[7:0]};
    end
  end

  assign N = S_out[15];
  assign Z = (S_out == 16'd0);
  assign V = arith & v_arith;
  assign C = arith & sum17[16];

endmodule

// File: tb/tb_register_file_plus_alu.sv
// Directed, table-driven bench for register_file_plus_alu.
// Bypass-dependent expectations follow the RF_BYPASS_EN macro.
module tb_register_file_plus_alu;

  logic        clk;
  logic        rst_n;
  logic        RF_en;
  logic [2:0]  RF_addr;
  logic [15:0] RF_data;
  logic [2:0]  read_A;
  logic [2:0]  read_B;
  logic [15:0] rA;
  logic [15:0] rB;
  logic        add_or_sub;
  logic        out_imm;
  logic [15:0] ext_B_data;
  logic        LHI;
  logic        LLI;
  logic [15:0] S_out;
  logic        N;
  logic        Z;
  logic        V;
  logic        C;
  logic        ctro_outR;
  logic [15:0] OutR;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        imm;
    logic [15:0] ext;
    logic        sub;
    logic        lhi;
    logic        lli;
    logic [15:0] exp_s;
    logic [3:0]  exp_f;
  } vec_t;

  vec_t vecs[12];

  register_file_plus_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RF_en      (RF_en),
    .RF_addr    (RF_addr),
    .RF_data    (RF_data),
    .read_A     (read_A),
    .read_B     (read_B),
    .rA         (rA),
    .rB         (rB),
    .add_or_sub (add_or_sub),
    .out_imm    (out_imm),
    .ext_B_data (ext_B_data),
    .LHI        (LHI),
    .LLI        (LLI),
    .S_out      (S_out),
    .N          (N),
    .Z          (Z),
    .V          (V),
    .C          (C),
    .ctro_outR  (ctro_outR),
    .OutR       (OutR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [15:0] d);
    RF_en   = 1'b1;
    RF_addr = a;
    RF_data = d;
    tick();
    RF_en   = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    read_A     = v.ra;
    read_B     = v.rb;
    out_imm    = v.imm;
    ext_B_data = v.ext;
    add_or_sub = v.sub;
    LHI        = v.lhi;
    LLI        = v.lli;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    RF_en = 1'b0;
    RF_addr = '0;
    RF_data = '0;
    read_A = '0;
    read_B = '0;
    add_or_sub = 1'b0;
    out_imm = 1'b0;
    ext_B_data = '0;
    LHI = 1'b0;
    LLI = 1'b0;
    ctro_outR = 1'b0;

    //          name        rA rB imm ext      sub lhi lli exp_s    NZVC
    vecs[0]  = '{"add_imm",  1, 0, 1, 16'h00FF, 0, 0, 0, 16'h1210, 4'b0000};
    vecs[1]  = '{"add_ovf",  2, 0, 1, 16'h0001, 0, 0, 0, 16'h8000, 4'b1010};
    vecs[2]  = '{"sub_zero", 7, 3, 0, 16'h0000, 1, 0, 0, 16'hAAAA, 4'b1001};
    vecs[3]  = '{"sub_eq",   7, 7, 0, 16'h0000, 1, 0, 0, 16'h0000, 4'b0101};
    vecs[4]  = '{"sub_brw",  3, 4, 0, 16'h0000, 1, 0, 0, 16'hFFFF, 4'b1000};
    vecs[5]  = '{"lhi",      1, 0, 1, 16'h9999, 0, 1, 0, 16'h9911, 4'b1000};
    vecs[6]  = '{"lli",      1, 0, 1, 16'h9999, 0, 0, 1, 16'h1199, 4'b0000};
    vecs[7]  = '{"lhi_lli",  1, 0, 1, 16'h9999, 0, 1, 1, 16'h9911, 4'b1000};
    vecs[8]  = '{"add_cv",   7, 7, 0, 16'h0000, 0, 0, 0, 16'h5554, 4'b0011};
    vecs[9]  = '{"sub_ovf",  2, 0, 1, 16'hFFFF, 1, 0, 0, 16'h8000, 4'b1010};
    vecs[10] = '{"lhi_sub",  7, 0, 1, 16'h0000, 1, 1, 0, 16'h00AA, 4'b0000};
    vecs[11] = '{"lli_z",    3, 0, 1, 16'h1200, 0, 0, 1, 16'h0000, 4'b0100};

    tick();
    rst_n = 1'b0;
    check("rst_outr", OutR, 16'h0000);
    read_A = 3'd4;
    read_B = 3'd6;
    #1;
    check("rst_ra4", rA, 16'h0000);
    check("rst_rb6", rB, 16'h0000);

    wr(3'd1, 16'h1111);
    read_B = 3'd1;
    read_A = 3'd5;
    #1;
    check("wr_rb1", rB, 16'h1111);
    check("rd_r5", rA, 16'h0000);

    wr(3'd7, 16'hAAAA);
    wr(3'd2, 16'h7FFF);
    wr(3'd4, 16'h0001);

    // write latency: R6 not visible before the edge
    RF_en   = 1'b1;
    RF_addr = 3'd6;
    RF_data = 16'h6666;
    read_A  = 3'd6;
    #1;
`ifdef RF_BYPASS_EN
    check("pre_edge_r6", rA, 16'h6666);
`else
    check("pre_edge_r6", rA, 16'h0000);
`endif
    tick();
    RF_en = 1'b0;
    check("post_edge_r6", rA, 16'h6666);

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      #1;
      check(vecs[i].name,
            {12'd0, S_out, N, Z, V, C},
            {12'd0, vecs[i].exp_s, vecs[i].exp_f});
    end

    apply(vecs[0]);
    ctro_outR = 1'b1;
    tick();
    check("outr_load", OutR, 16'h1210);
    ctro_outR = 1'b0;
    apply(vecs[2]);
    tick();
    check("outr_hold", OutR, 16'h1210);
    check("outr_hold_s", S_out, 16'hAAAA);

    // same-cycle write of R1 with OutR capture
    apply(vecs[0]);
    RF_en     = 1'b1;
    RF_addr   = 3'd1;
    RF_data   = 16'h2222;
    ctro_outR = 1'b1;
    tick();
    RF_en     = 1'b0;
    ctro_outR = 1'b0;
`ifdef RF_BYPASS_EN
    check("same_cyc_outr", OutR, 16'h2321);
`else
    check("same_cyc_outr", OutR, 16'h1210);
`endif
    check("same_cyc_s", S_out, 16'h2321);

`ifdef RF_BYPASS_EN
    RF_en   = 1'b1;
    RF_addr = 3'd2;
    RF_data = 16'h5555;
    read_A  = 3'd2;
    #1;
    check("bypass_ra", rA, 16'h5555);
    rst_n = 1'b1;
    #1;
    check("bypass_rst", rA, 16'h7FFF);
    rst_n = 1'b0;
    tick();
    RF_en = 1'b0;
`endif

    // reset wins over concurrent write and OutR load
    rst_n     = 1'b1;
    RF_en     = 1'b1;
    RF_addr   = 3'd3;
    RF_data   = 16'hBEEF;
    ctro_outR = 1'b1;
    tick();
    rst_n     = 1'b0;
    RF_en     = 1'b0;
    ctro_outR = 1'b0;
    check("rst2_outr", OutR, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      read_A = 3'(i);
      read_B = 3'(7 - i);
      #1;
      check($sformatf("rst2_ra%0d", i), rA, 16'h0000);
      check($sformatf("rst2_rb%0d", 7 - i), rB, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
